jtsdram_ba_sched: RTL
=====================

Name: jtsdram_ba_sched

Overview:
- Request scheduler between the SDRAM test traffic sources and the 4-bank SDRAM port (ba_rd/ba_wr/ba_ack/ba_rdy).
- Accepts one request per bank from client logic and drives the bank strobes and addresses.
- Caps the number of concurrently outstanding bank operations and admits new ones round-robin.
- Captures 32-bit read data per bank. Flags banks whose operation never completes (timeout), so the video/LED logic can report a stuck bank.

Parameters:
MAXOUT, 4, maximum banks simultaneously in flight (1..4)
TOUT, 1023, cycles allowed from strobe assertion to ba_rdy before timeout
TW, 10, width of per-bank timeout counter (must hold TOUT)

Ports:
clk  in  1  system clock (48/96 MHz)
rst  in  1  asynchronous reset, active-high
cl_req  in  4  per-bank request, level; held until cl_ack
cl_we  in  1  bank 0 request is a write (sampled with grant)
cl_addr  in  88  4x22 request addresses, bank n at [22n+21:22n]
cl_din  in  16  bank 0 write data
cl_din_m  in  2  bank 0 write mask
cl_ack  out  4  one-cycle pulse: request accepted, inputs latched
cl_valid  out  4  one-cycle pulse: operation complete
cl_dout  out  128  4x32 captured read data, bank n at [32n+31:32n]
cl_tout  out  4  sticky timeout flag per bank
ba_rd  out  4  bank read strobes
ba_wr  out  1  bank 0 write strobe
ba0_addr..ba3_addr  out  22 each  bank addresses
ba0_din  out  16  write data
ba0_din_m  out  2  write mask
ba_ack  in  4  controller accepted the command
ba_rdy  in  4  operation finished; read data valid on data_read
data_read  in  32  SDRAM read data

Behaviour:
- Reset: all outputs 0, all bank FSMs IDLE, round-robin pointer = 0, cl_tout cleared. Only rst clears cl_tout.
- Per-bank FSM, 3 states:
  - IDLE: the bank waits for a grant. On grant it latches address, plus we/din/mask for bank 0. It pulses cl_ack[n] and moves to CMD.
  - CMD: ba_rd[n] or ba_wr is asserted, registered, from the cycle after the grant. On ba_ack[n] the strobe drops the next cycle and the FSM moves to DATA. If ba_ack[n] and ba_rdy[n] arrive in the same cycle, the FSM goes directly to completion: capture data, pulse cl_valid[n], return to IDLE.
  - DATA: on ba_rdy[n], a read latches data_read into cl_dout[n]; a write leaves cl_dout unchanged. cl_valid[n] pulses and the FSM returns to IDLE.
- Timeout:
  - The counter loads 0 on entering CMD and increments in CMD/DATA.
  - When it reaches TOUT: set cl_tout[n], drop the strobe, return to IDLE, and give no cl_valid.
  - ba_ack/ba_rdy for bank n seen while in IDLE are ignored.
- Admission:
  - outstanding = number of banks in CMD or DATA.
  - At most one grant per cycle, and only when outstanding < MAXOUT.
  - The candidate set is banks with cl_req=1 in IDLE. The winner is the first candidate at or after the pointer (mod 4).
  - After a grant the pointer = winner+1 (mod 4).
  - A bank that completes in cycle t may be re-granted from t+1.
- cl_we applies only to bank 0; banks 1-3 are always reads.
- ba_wr and ba_rd[0] are never both 1.
- Latency: grant at edge t; strobe high at t+1; the earliest cl_valid is the cycle after ba_rdy.
- Reset mid-operation: strobes drop immediately (async). Any in-flight SDRAM transaction is abandoned; its late ack/rdy is ignored in IDLE.

Decomposition:
- Package jtsdram_pkg: FSM state encoding (IDLE/CMD/DATA), bank count constant 4, address width 22, data width 32.
- Sub-module jtsdram_ba_chan: one per-bank FSM with timeout counter and latches, instantiated 4x via generate.
- The top level holds the round-robin admission logic and the outstanding counter.

Test Plan:
1. Single read, bank 2:
   - Stimulus: cl_req=0100, addr 0x12345; ba_ack 3 cycles later; ba_rdy 5 cycles after that with data_read=0xDEADBEEF.
   - Required: ba2_addr=0x12345; ba_rd=0100 for exactly 3 cycles; cl_valid[2] one pulse; cl_dout[2]=0xDEADBEEF.
2. Bank 0 write:
   - Stimulus: cl_we=1, din=0xA55A, mask=01.
   - Required: ba_wr=1 with ba0_din=0xA55A, ba0_din_m=01; ba_rd[0]=0; cl_valid[0] after ba_rdy[0]; cl_dout[0] unchanged.
3. Round-robin and cap:
   - Stimulus: MAXOUT=2, cl_req=1111 from reset, controller never responds until released.
   - Required: grants bank0 then bank1 on consecutive cycles; banks 2/3 wait; after bank0 completes, bank2 is granted before bank3.
4. Timeout:
   - Stimulus: TOUT=15, bank 1 requested, ba_ack never asserted.
   - Required: ba_rd[1] drops after 15 cycles; cl_tout=0010 stays set; no cl_valid; a later ba_ack[1] is ignored.
5. Simultaneous ack+rdy:
   - Stimulus: bank 3 read, ba_ack[3] and ba_rdy[3] in the same cycle.
   - Required: cl_valid[3] next cycle with captured data; FSM IDLE.
6. Async reset mid-DATA:
   - Stimulus: rst pulsed while banks 0 and 2 are in flight.
   - Required: all strobes and cl_tout are 0 immediately; the post-reset ba_rdy[2] produces no cl_valid.

Source files
------------

// File: rtl/jtsdram_pkg.sv
// Shared constants for the SDRAM bank request scheduler.
// Contents: bank count, address/data widths, per-bank FSM state encoding.
// No logic; imported by the interface, the bank channel and the scheduler top.
package jtsdram_pkg;
  localparam int NBANK = 4;
  localparam int AW    = 22;
  localparam int DW    = 32;

  typedef logic [1:0] state_t;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CMD  = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;
endpackage

// File: rtl/jtsdram_ba_sched_if.sv
// Bundle of the client request side and the 4-bank SDRAM port.
// slave: the scheduler (takes cl_req/cl_*, drives ba_* strobes and addresses).
// master: the traffic source plus SDRAM controller side (drives requests, ack/rdy/data).
interface jtsdram_ba_sched_if;
  import jtsdram_pkg::*;

  // client side
  logic [NBANK-1:0]    cl_req;
  logic                cl_we;
  logic [NBANK*AW-1:0] cl_addr;
  logic [15:0]         cl_din;
  logic [1:0]          cl_din_m;
  logic [NBANK-1:0]    cl_ack;
  logic [NBANK-1:0]    cl_valid;
  logic [NBANK*DW-1:0] cl_dout;
  logic [NBANK-1:0]    cl_tout;
  // SDRAM bank side
  logic [NBANK-1:0]    ba_rd;
  logic                ba_wr;
  logic [AW-1:0]       ba0_addr;
  logic [AW-1:0]       ba1_addr;
  logic [AW-1:0]       ba2_addr;
  logic [AW-1:0]       ba3_addr;
  logic [15:0]         ba0_din;
  logic [1:0]          ba0_din_m;
  logic [NBANK-1:0]    ba_ack;
  logic [NBANK-1:0]    ba_rdy;
  logic [DW-1:0]       data_read;

  modport slave (
    input  cl_req, cl_we, cl_addr, cl_din, cl_din_m, ba_ack, ba_rdy, data_read,
    output cl_ack, cl_valid, cl_dout, cl_tout, ba_rd, ba_wr,
           ba0_addr, ba1_addr, ba2_addr, ba3_addr, ba0_din, ba0_din_m
  );

  modport master (
    output cl_req, cl_we, cl_addr, cl_din, cl_din_m, ba_ack, ba_rdy, data_read,
    input  cl_ack, cl_valid, cl_dout, cl_tout, ba_rd, ba_wr,
           ba0_addr, ba1_addr, ba2_addr, ba3_addr, ba0_din, ba0_din_m
  );
endinterface

// File: rtl/jtsdram_ba_chan.sv
// One SDRAM bank channel: IDLE -> CMD (strobe up) -> DATA -> IDLE, with timeout.
// Latency: strobe and ack_o rise on the grant edge; valid_o the cycle after rdy_i.
// Backpressure: strobe held until ack_i; gives up after TOUT cycles and sets sticky tout_o.
// Ports: grant_i/we_i/addr_i from admission, ack_i/rdy_i/data_i from the controller,
//        rd_o/wr_o/addr_o to the bank, ack_o/valid_o/dout_o/tout_o/busy_o to client/top.
module jtsdram_ba_chan
  import jtsdram_pkg::*;
#(
  parameter int TOUT = 1023,
  parameter int TW   = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          grant_i,
  input  logic          we_i,
  input  logic [AW-1:0] addr_i,
  input  logic          ack_i,
  input  logic          rdy_i,
  input  logic [DW-1:0] data_i,
  output logic          busy_o,
  output logic          ack_o,
  output logic          valid_o,
  output logic          tout_o,
  output logic          rd_o,
  output logic          wr_o,
  output logic [AW-1:0] addr_o,
  output logic [DW-1:0] dout_o
);
  state_t        st_q, st_d;
  logic          we_q, we_d, rd_q, rd_d, wr_q, wr_d;
  logic          ack_q, ack_d, valid_q, valid_d, tout_q, tout_d;
  logic [TW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] dout_q, dout_d;
  logic          expire, done;

  // cnt_q counts cycles since the grant edge; this edge is the TOUT-th one
  assign expire = (cnt_q == TW'(TOUT - 1));
  // rdy only counts once the command was accepted (same cycle as ack, or later)
  assign done   = rdy_i & ((st_q == ST_DATA) | ((st_q == ST_CMD) & ack_i));

  always_comb begin
    st_d    = st_q;
    we_d    = we_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    ack_d   = 1'b0;
    valid_d = 1'b0;
    tout_d  = tout_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    dout_d  = dout_q;
    case (st_q)
      ST_IDLE: begin
        if (grant_i) begin
          st_d   = ST_CMD;
          addr_d = addr_i;
          we_d   = we_i;
          rd_d   = ~we_i;
          wr_d   = we_i;
          cnt_d  = '0;
          ack_d  = 1'b1;
        end
      end
      ST_CMD, ST_DATA: begin
        cnt_d = cnt_q + TW'(1);
        if (done) begin
          st_d    = ST_IDLE;
          valid_d = 1'b1;
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          if (!we_q) dout_d = data_i;
        end else if ((st_q == ST_CMD) && ack_i) begin
          st_d = ST_DATA;
          rd_d = 1'b0;
          wr_d = 1'b0;
        end else if (expire) begin
          st_d   = ST_IDLE;
          tout_d = 1'b1;
          rd_d   = 1'b0;
          wr_d   = 1'b0;
        end
      end
      default: st_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q    <= ST_IDLE;
      we_q    <= 1'b0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      ack_q   <= 1'b0;
      valid_q <= 1'b0;
      tout_q  <= 1'b0;
      cnt_q   <= '0;
      addr_q  <= '0;
      dout_q  <= '0;
    end else begin
      st_q    <= st_d;
      we_q    <= we_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      ack_q   <= ack_d;
      valid_q <= valid_d;
      tout_q  <= tout_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      dout_q  <= dout_d;
    end
  end

  assign busy_o  = (st_q != ST_IDLE);
  assign ack_o   = ack_q;
  assign valid_o = valid_q;
  assign tout_o  = tout_q;
  assign rd_o    = rd_q;
  assign wr_o    = wr_q;
  assign addr_o  = addr_q;
  assign dout_o  = dout_q;
endmodule

// File: rtl/jtsdram_ba_sched.sv
// Round-robin admission of per-bank client requests onto the 4-bank SDRAM port.
// Latency: grant decided combinationally, cl_ack and strobe registered on the grant edge.
// Backpressure: at most one grant per cycle and no grant while MAXOUT banks are busy.
// Ports: clk, rst (async, active-high), bus (slave side of jtsdram_ba_sched_if).
module jtsdram_ba_sched
  import jtsdram_pkg::*;
#(
  parameter int MAXOUT = 4,
  parameter int TOUT   = 1023,
  parameter int TW     = 10
) (
  input logic               clk,
  input logic               rst,
  jtsdram_ba_sched_if.slave bus
);
  logic [NBANK-1:0]         busy, cand, grant, rd, wr, tout, ack, valid;
  logic [NBANK-1:0][AW-1:0] addr;
  logic [NBANK-1:0][DW-1:0] dout;
  logic [1:0]               ptr_q, ptr_d, idx;
  logic [2:0]               nout;
  logic [15:0]              din_q;
  logic [1:0]               din_m_q;

  assign cand = bus.cl_req & ~busy;

  always_comb begin
    nout = '0;
    for (int i = 0; i < NBANK; i++) nout = nout + {2'b00, busy[i]};
  end

  // first requesting idle bank at or after the pointer wins
  always_comb begin
    grant = '0;
    ptr_d = ptr_q;
    idx   = '0;
    if (nout < 3'(MAXOUT)) begin
      for (int i = 0; i < NBANK; i++) begin
        idx = ptr_q + 2'(i);
        if ((grant == '0) && cand[idx]) begin
          grant[idx] = 1'b1;
          ptr_d      = idx + 2'd1;
        end
      end
    end
  end

  // bank 0 write payload, captured together with the bank 0 grant
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q   <= '0;
      din_q   <= '0;
      din_m_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      if (grant[0]) begin
        din_q   <= bus.cl_din;
        din_m_q <= bus.cl_din_m;
      end
    end
  end

  for (genvar g = 0; g < NBANK; g++) begin : g_chan
    jtsdram_ba_chan #(
      .TOUT (TOUT),
      .TW   (TW)
    ) u_chan (
      .clk     (clk),
      .rst     (rst),
      .grant_i (grant[g]),
      .we_i    ((g == 0) ? bus.cl_we : 1'b0),
      .addr_i  (bus.cl_addr[AW*g +: AW]),
      .ack_i   (bus.ba_ack[g]),
      .rdy_i   (bus.ba_rdy[g]),
      .data_i  (bus.data_read),
      .busy_o  (busy[g]),
      .ack_o   (ack[g]),
      .valid_o (valid[g]),
      .tout_o  (tout[g]),
      .rd_o    (rd[g]),
      .wr_o    (wr[g]),
      .addr_o  (addr[g]),
      .dout_o  (dout[g])
    );
  end

  assign bus.cl_ack    = ack;
  assign bus.cl_valid  = valid;
  assign bus.cl_tout   = tout;
  assign bus.cl_dout   = dout;
  assign bus.ba_rd     = rd;
  // only bank 0 ever latches we=1, so the OR is bank 0's write strobe
  assign bus.ba_wr     = |wr;
  assign bus.ba0_addr  = addr[0];
  assign bus.ba1_addr  = addr[1];
  assign bus.ba2_addr  = addr[2];
  assign bus.ba3_addr  = addr[3];
  assign bus.ba0_din   = din_q;
  assign bus.ba0_din_m = din_m_q;
endmodule
